redmule_tile_event_unit: RTL and testbench



---
 rtl/redmule_tile_pkg.sv | 35 +++
 rtl/redmule_tile_event_unit.sv | 127 ++++++++++++
 tb/tb_redmule_tile_event_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/redmule_tile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// redmule_tile_pkg: shared types and register map of the tile event unit.
// Rev 1.0
// ---------------------------------------------------------------------------
package redmule_tile_pkg;

    typedef enum logic [1:0] {
        EVT_IDLE  = 2'd0,
        EVT_SLEEP = 2'd1,
        EVT_WAKE  = 2'd2
    } evt_fsm_e;

    localparam logic [3:0] EVT_REG_WAKE_MASK = 4'd0;
    localparam logic [3:0] EVT_REG_IRQ_MASK  = 4'd1;
    localparam logic [3:0] EVT_REG_PENDING   = 4'd2;
    localparam logic [3:0] EVT_REG_CLEAR     = 4'd3;
    localparam logic [3:0] EVT_REG_SET       = 4'd4;
    localparam logic [3:0] EVT_REG_STATUS    = 4'd5;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
    } evt_reg_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } evt_reg_rsp_t;

endpackage
`default_nettype wire

// File: rtl/redmule_tile_event_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// redmule_tile_event_unit: latches accelerator/software events, drives core
// wfe wake-up and a masked level IRQ. Rev 1.0
// ---------------------------------------------------------------------------
module redmule_tile_event_unit
    import redmule_tile_pkg::*;
#(
    parameter int unsigned N_ACC_EVT = 2,
    parameter int unsigned N_SW_EVT  = 8,
    parameter int unsigned IRQ_ID    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_ACC_EVT-1:0] acc_evt_i,
    input  logic                 acc_busy_i,
    input  logic                 core_sleep_i,
    input  logic                 reg_req_i,
    input  logic                 reg_we_i,
    input  logic [3:0]           reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    output logic                 reg_gnt_o,
    output logic                 reg_rvalid_o,
    output logic [31:0]          reg_rdata_o,
    output logic                 wu_wfe_o,
    output logic [31:0]          irq_o
);

    localparam int unsigned N_EVT = N_ACC_EVT + 1 + N_SW_EVT;
    localparam logic [N_EVT-1:0] SW_MASK = {{N_SW_EVT{1'b1}}, {(N_ACC_EVT + 1){1'b0}}};

    if (N_EVT > 32 || IRQ_ID > 31) begin : g_param_check
        $error("redmule_tile_event_unit: N_EVT must be <= 32 and IRQ_ID <= 31");
    end

    evt_reg_req_t req;
    evt_reg_rsp_t rsp;

    assign req = '{req: reg_req_i, we: reg_we_i, addr: reg_addr_i, wdata: reg_wdata_i};

    evt_fsm_e         state_q, state_n;
    logic             busy_q;
    logic             busy_fall;
    logic [N_EVT-1:0] pend_q, pend_n;
    logic [N_EVT-1:0] wake_mask_q, irq_mask_q;
    logic [N_EVT-1:0] hw_ev, set_ev, clr_ev;
    logic             wr_en;
    logic             wu_q, irq_q;
    logic             rvalid_q;
    logic [31:0]      rdata_q, rdata_n;
    logic             unused_wdata;

    // Event fires on the cycle the accelerator leaves the busy state.
    assign busy_fall = busy_q & ~acc_busy_i;
    assign hw_ev     = {{N_SW_EVT{1'b0}}, busy_fall, acc_evt_i};
    assign wr_en     = req.req & req.we;
    assign unused_wdata = ^(req.wdata >> N_EVT);

    always_comb begin
        set_ev = '0;
        clr_ev = '0;
        if (wr_en && req.addr == EVT_REG_CLEAR) clr_ev = req.wdata[N_EVT-1:0];
        if (wr_en && req.addr == EVT_REG_SET)   set_ev = req.wdata[N_EVT-1:0] & SW_MASK;
        // Sets applied after the clear so a coincident event is never lost.
        pend_n = (pend_q & ~clr_ev) | set_ev | hw_ev;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            EVT_IDLE:  if (core_sleep_i) state_n = EVT_SLEEP;
            EVT_SLEEP: begin
                if (!core_sleep_i)                  state_n = EVT_IDLE;
                else if (|(pend_q & wake_mask_q))   state_n = EVT_WAKE;
            end
            EVT_WAKE:  if (!core_sleep_i) state_n = EVT_IDLE;
            default:   state_n = EVT_IDLE;
        endcase
    end

    always_comb begin
        rdata_n = '0;
        if (req.req && !req.we) begin
            case (req.addr)
                EVT_REG_WAKE_MASK: rdata_n = 32'(wake_mask_q);
                EVT_REG_IRQ_MASK:  rdata_n = 32'(irq_mask_q);
                EVT_REG_PENDING:   rdata_n = 32'(pend_q);
                EVT_REG_STATUS:    rdata_n = {29'd0, state_q, busy_q};
                default:           rdata_n = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= EVT_IDLE;
            busy_q      <= 1'b0;
            pend_q      <= '0;
            wake_mask_q <= '0;
            irq_mask_q  <= '0;
            wu_q        <= 1'b0;
            irq_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q  <= state_n;
            busy_q   <= acc_busy_i;
            pend_q   <= pend_n;
            wu_q     <= (state_n == EVT_WAKE);
            irq_q    <= |(pend_q & irq_mask_q);
            rvalid_q <= req.req;
            rdata_q  <= rdata_n;
            if (wr_en && req.addr == EVT_REG_WAKE_MASK) wake_mask_q <= req.wdata[N_EVT-1:0];
            if (wr_en && req.addr == EVT_REG_IRQ_MASK)  irq_mask_q  <= req.wdata[N_EVT-1:0];
        end
    end

    assign rsp = '{gnt: req.req, rvalid: rvalid_q, rdata: rdata_q};

    assign reg_gnt_o    = rsp.gnt;
    assign reg_rvalid_o = rsp.rvalid;
    assign reg_rdata_o  = rsp.rdata;
    assign wu_wfe_o     = wu_q;
    assign irq_o        = 32'(irq_q) << IRQ_ID;

endmodule
`default_nettype wire

// File: tb/tb_redmule_tile_event_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_redmule_tile_event_unit: directed bench with read-response scoreboard.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_redmule_tile_event_unit;

    localparam logic [31:0] IRQ_BIT = 32'h0001_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  acc_evt_i;
    logic        acc_busy_i;
    logic        core_sleep_i;
    logic        reg_req_i;
    logic        reg_we_i;
    logic [3:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic        reg_gnt_o;
    logic        reg_rvalid_o;
    logic [31:0] reg_rdata_o;
    logic        wu_wfe_o;
    logic [31:0] irq_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_data_q[$];
    bit          exp_rd_q[$];
    logic [3:0]  exp_addr_q[$];

    redmule_tile_event_unit #(.N_ACC_EVT(2), .N_SW_EVT(8), .IRQ_ID(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .acc_evt_i    (acc_evt_i),
        .acc_busy_i   (acc_busy_i),
        .core_sleep_i (core_sleep_i),
        .reg_req_i    (reg_req_i),
        .reg_we_i     (reg_we_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_gnt_o    (reg_gnt_o),
        .reg_rvalid_o (reg_rvalid_o),
        .reg_rdata_o  (reg_rdata_o),
        .wu_wfe_o     (wu_wfe_o),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every response pops one expectation; reads are compared.
    always @(negedge clk_i) begin
        if (!rst_i && reg_rvalid_o) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got rvalid with empty scoreboard");
            end else begin
                logic [31:0] e_data;
                bit          e_rd;
                logic [3:0]  e_addr;
                e_data = exp_data_q.pop_front();
                e_rd   = exp_rd_q.pop_front();
                e_addr = exp_addr_q.pop_front();
                if (e_rd) begin
                    checks++;
                    if (reg_rdata_o !== e_data) begin
                        errors++;
                        $display("FAIL rdata_addr%0d: got 0x%08h expected 0x%08h", e_addr, reg_rdata_o, e_data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic reg_access(input bit we, input logic [3:0] addr, input logic [31:0] data,
                              input logic [31:0] exp);
        reg_req_i   = 1'b1;
        reg_we_i    = we;
        reg_addr_i  = addr;
        reg_wdata_i = data;
        #1;
        check("gnt", {31'd0, reg_gnt_o}, 32'd1);
        exp_data_q.push_back(exp);
        exp_rd_q.push_back(!we);
        exp_addr_q.push_back(addr);
        step();
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
        reg_wdata_i = '0;
    endtask

    task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
        reg_access(1'b1, addr, data, 32'd0);
    endtask

    task automatic reg_read(input logic [3:0] addr, input logic [31:0] exp);
        reg_access(1'b0, addr, 32'd0, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; acc_evt_i = '0; acc_busy_i = 1'b0; core_sleep_i = 1'b0;
        reg_req_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
        repeat (3) step();
        rst_i = 1'b0;

        // Reset state
        check("reset_wu", {31'd0, wu_wfe_o}, 32'd0);
        check("reset_irq", irq_o, 32'd0);
        check("reset_gnt_idle", {31'd0, reg_gnt_o}, 32'd0);
        for (int a = 0; a < 6; a++) reg_read(4'(a), 32'd0);
        reg_read(4'd9, 32'd0);

        // Accelerator event wakes a sleeping core
        reg_write(4'd0, 32'h1);
        core_sleep_i = 1'b1;
        step();
        acc_evt_i = 2'b01;
        step();
        acc_evt_i = 2'b00;
        check("wake_wu_before", {31'd0, wu_wfe_o}, 32'd0);
        reg_read(4'd2, 32'h1);
        check("wake_wu_high", {31'd0, wu_wfe_o}, 32'd1);
        reg_read(4'd5, 32'h4);
        core_sleep_i = 1'b0;
        step();
        check("wake_wu_drop", {31'd0, wu_wfe_o}, 32'd0);
        reg_read(4'd5, 32'h0);
        reg_write(4'd3, 32'h1);
        reg_write(4'd0, 32'h0);

        // Busy falling edge raises the IRQ
        reg_write(4'd1, 32'h4);
        acc_busy_i = 1'b1;
        step();
        reg_read(4'd5, 32'h1);
        acc_busy_i = 1'b0;
        step();
        check("irq_one_after_fall", irq_o, 32'd0);
        step();
        check("irq_two_after_fall", irq_o, IRQ_BIT);
        reg_read(4'd2, 32'h4);
        reg_write(4'd3, 32'h4);
        step();
        check("irq_cleared", irq_o, 32'd0);
        reg_write(4'd1, 32'h0);

        // SET field masking, CLEAR, register width, unmapped address
        reg_write(4'd4, 32'hF);
        reg_read(4'd2, 32'h8);
        reg_write(4'd3, 32'h8);
        reg_read(4'd2, 32'h0);
        reg_write(4'd0, 32'hFFFF_FFFF);
        reg_read(4'd0, 32'h7FF);
        reg_write(4'd0, 32'h0);
        reg_write(4'd7, 32'hDEAD_BEEF);
        reg_read(4'd7, 32'h0);

        // Hardware event coincident with CLEAR of the same bit survives
        acc_evt_i = 2'b01;
        step();
        reg_write(4'd3, 32'h1);
        acc_evt_i = 2'b00;
        reg_read(4'd2, 32'h1);

        // Pending already set before sleep: wake within two cycles
        reg_write(4'd0, 32'h1);
        core_sleep_i = 1'b1;
        step();
        check("presleep_wu_c1", {31'd0, wu_wfe_o}, 32'd0);
        step();
        check("presleep_wu_c2", {31'd0, wu_wfe_o}, 32'd1);
        reg_write(4'd1, 32'h1);
        step();
        check("presleep_irq", irq_o, IRQ_BIT);

        // Reset while in WAKE
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        core_sleep_i = 1'b0;
        check("rst_wu", {31'd0, wu_wfe_o}, 32'd0);
        check("rst_irq", irq_o, 32'd0);
        reg_read(4'd5, 32'h0);
        reg_read(4'd2, 32'h0);
        reg_read(4'd0, 32'h0);
        reg_read(4'd1, 32'h0);

        // Mask cleared while sleeping, then spurious wake
        reg_write(4'd0, 32'h1);
        core_sleep_i = 1'b1;
        step();
        reg_write(4'd0, 32'h0);
        acc_evt_i = 2'b01;
        step();
        acc_evt_i = 2'b00;
        step();
        check("masked_wu", {31'd0, wu_wfe_o}, 32'd0);
        reg_read(4'd5, 32'h2);
        core_sleep_i = 1'b0;
        step();
        check("spurious_wu", {31'd0, wu_wfe_o}, 32'd0);
        reg_read(4'd5, 32'h0);

        step();
        step();
        checks++;
        if (exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL missing_rvalid: got %0d outstanding expected 0", exp_rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
